// File: rtl/range_scan_ctrl.sv
// Address-range scan sequencer: orders two search addresses, walks lo..hi over a
// req/ack match-memory port and records hits. Optional build macro: RANGE_SCAN_STOP_ON_HIT_EN.
module range_scan_ctrl #(
    parameter int AW          = 5,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic          mem_hit,
    output logic          busy,
    output logic          done,
    output logic          same,
    output logic          found,
    output logic [AW-1:0] found_addr,
    output logic [AW:0]   hit_count,
    output logic          timeout_err
);

    // The wait timer only ever needs to reach ACK_TIMEOUT-1 before aborting.
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

`ifdef RANGE_SCAN_STOP_ON_HIT_EN
    localparam logic STOP_ON_HIT = 1'b1;
`else
    localparam logic STOP_ON_HIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] hi_q, hi_d;
    logic [AW-1:0] cur_q, cur_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          same_q, same_d;
    logic          found_q, found_d;
    logic [AW-1:0] found_addr_q, found_addr_d;
    logic [AW:0]   hit_count_q, hit_count_d;
    logic          timeout_err_q, timeout_err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            hi_q          <= '0;
            cur_q         <= '0;
            timer_q       <= '0;
            same_q        <= 1'b0;
            found_q       <= 1'b0;
            found_addr_q  <= '0;
            hit_count_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hi_q          <= hi_d;
            cur_q         <= cur_d;
            timer_q       <= timer_d;
            same_q        <= same_d;
            found_q       <= found_d;
            found_addr_q  <= found_addr_d;
            hit_count_q   <= hit_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hi_d          = hi_q;
        cur_d         = cur_q;
        timer_d       = timer_q;
        same_d        = same_q;
        found_d       = found_q;
        found_addr_d  = found_addr_q;
        hit_count_d   = hit_count_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_d         = (addr_a < addr_b) ? addr_a : addr_b;
                    hi_d          = (addr_a < addr_b) ? addr_b : addr_a;
                    same_d        = (addr_a == addr_b);
                    found_d       = 1'b0;
                    found_addr_d  = '0;
                    hit_count_d   = '0;
                    timeout_err_d = 1'b0;
                    timer_d       = '0;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                // Abort takes priority, so a coincident transfer is dropped entirely.
                if (abort) begin
                    state_d = IDLE;
                end else if (mem_ack) begin
                    timer_d = '0;
                    if (mem_hit) begin
                        hit_count_d = hit_count_q + 1'b1;
                        if (!found_q) begin
                            found_d      = 1'b1;
                            found_addr_d = cur_q;
                        end
                    end
                    // Termination is decided before incrementing so hi = all-ones never wraps.
                    if ((cur_q == hi_q) || (STOP_ON_HIT && mem_hit)) begin
                        state_d = DONE;
                    end else begin
                        cur_d = cur_q + 1'b1;
                    end
                end else if ((ACK_TIMEOUT != 0) && (timer_q == TIMER_LAST)) begin
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_req     = (state_q == ISSUE);
    assign mem_addr    = cur_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign same        = same_q;
    assign found       = found_q;
    assign found_addr  = found_addr_q;
    assign hit_count   = hit_count_q;
    assign timeout_err = timeout_err_q;

endmodule
